aes_sub_bytes_seq: RTL and testbench

//   Parametrised, multi-cycle AES SubBytes engine for the aes128 datapath. Applies the

---
 rtl/aes_sub_bytes_seq_pkg.sv | 62 ++++++
 rtl/aes_sub_bytes_seq_if.sv | 27 ++
 rtl/aes_sub_bytes_seq_sbox_lane.sv | 28 ++
 rtl/aes_sub_bytes_seq.sv | 94 +++++++++
 tb/tb_aes_sub_bytes_seq.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sub_bytes_seq_pkg.sv
// Shared AES SubBytes definitions: byte count, FSM encoding, S-box lookups.
// Pure constants and combinational functions, no latency of their own.
// No flow control here; reused by the SubBytes engine and key expansion.
package aes_sub_bytes_seq_pkg;

    localparam int AES_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    // Inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[8*(255 - int'(b)) +: 8];
    endfunction

endpackage

// File: rtl/aes_sub_bytes_seq_if.sv
// Block-level handshake bundle between the round controller and SubBytes engine.
// Wires only, no latency.
// Valid/ready on both the input block and the output block.
interface aes_sub_bytes_seq_if;
    import aes_sub_bytes_seq_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [AES_BYTES*8-1:0]   in_state;
    logic                     in_inv;
    logic                     out_valid;
    logic                     out_ready;
    logic [AES_BYTES*8-1:0]   out_state;
    logic                     busy;

    // Controller side.
    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    // Engine side.
    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/aes_sub_bytes_seq_sbox_lane.sv
// One S-box lane: byte in, substituted byte out, inverse select.
// Combinational, zero cycles.
// No flow control; the parent sequences the lane inputs.
import aes_sub_bytes_seq_pkg::*;

module aes_sub_bytes_seq_sbox_lane #(
    parameter int INV_EN = 1
) (
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    generate
        if (INV_EN != 0) begin : g_inv
            // Both tables present; mode picks the direction.
            always_comb begin
                dout = inv ? inv_sbox(din) : sbox(din);
            end
        end else begin : g_fwd
            // Forward table only; the mode input has nothing to steer.
            logic unused_inv;
            assign unused_inv = inv;
            assign dout = sbox(din);
        end
    endgenerate

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Multi-cycle AES SubBytes: LANES bytes substituted per cycle over a 16-byte state.
// Latency: accept at edge E, out_valid high after edge E + 16/LANES.
// One block in flight; in_ready low while BUSY/DONE, output held until out_ready.
import aes_sub_bytes_seq_pkg::*;

module aes_sub_bytes_seq #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input logic              clk,
    input logic              reset,
    aes_sub_bytes_seq_if.slave bus
);

    localparam int NGRP = AES_BYTES / LANES;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [AES_BYTES*8-1:0] work;
    logic                   mode;
    logic                   accept;
    logic                   last;
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];

    assign accept        = bus.in_valid & bus.in_ready;
    assign last          = (cnt == CW'(NGRP - 1));
    assign bus.in_ready  = (state == ST_IDLE) & ~reset;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_state = work;
    assign bus.busy      = (state != ST_IDLE);

    // Steer the byte group selected by cnt onto the lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work[8*(int'(cnt)*LANES + l) +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sub_bytes_seq_sbox_lane #(.INV_EN(INV_EN)) u_lane (
            .din  (lane_in[g]),
            .inv  (mode),
            .dout (lane_out[g])
        );
    end

    // FSM state register; reset drops any block in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE -> BUSY on accept, BUSY -> DONE after last group, DONE -> IDLE on out handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)        state_nxt = ST_BUSY;
            ST_BUSY: if (last)          state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Working register: load on accept, overwrite one byte group per BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work <= '0;
            cnt  <= '0;
            mode <= 1'b0;
        end else if (accept) begin
            work <= bus.in_state;
            mode <= bus.in_inv & (INV_EN != 0);
            cnt  <= '0;
        end else if (state == ST_BUSY) begin
            for (int l = 0; l < LANES; l++) begin
                work[8*(int'(cnt)*LANES + l) +: 8] <= lane_out[l];
            end
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: six instances (LANES 1,2,4,8,16 with inverse, LANES 4 forward-only).
// Reference S-boxes are derived from GF(2^8) inversion plus the affine map.
// Instance 2 (LANES=4, INV_EN=1) carries the functional, back-pressure and reset scenarios.
module tb_aes_sub_bytes_seq;

    localparam int NDUT = 6;

    logic clk;
    logic reset;

    logic         in_valid_a  [NDUT];
    logic [127:0] in_state_a  [NDUT];
    logic         in_inv_a    [NDUT];
    logic         out_ready_a [NDUT];
    logic         in_ready_a  [NDUT];
    logic         out_valid_a [NDUT];
    logic [127:0] out_state_a [NDUT];
    logic         busy_a      [NDUT];

    int errors = 0;
    int checks = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L  = (g == 5) ? 4 : (1 << g);
        localparam int IE = (g == 5) ? 0 : 1;
        aes_sub_bytes_seq_if bus ();
        assign bus.in_valid   = in_valid_a[g];
        assign bus.in_state   = in_state_a[g];
        assign bus.in_inv     = in_inv_a[g];
        assign bus.out_ready  = out_ready_a[g];
        assign in_ready_a[g]  = bus.in_ready;
        assign out_valid_a[g] = bus.out_valid;
        assign out_state_a[g] = bus.out_state;
        assign busy_a[g]      = bus.busy;
        aes_sub_bytes_seq #(.LANES(L), .INV_EN(IE)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        if (x == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] affine_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    task automatic build_tables();
        for (int i = 0; i < 256; i++) fwd_tbl[i] = affine_sbox(8'(i));
        for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? inv_tbl[st[8*i +: 8]] : fwd_tbl[st[8*i +: 8]];
        return r;
    endfunction

    function automatic int lanes_of(input int d);
        return (d == 5) ? 4 : (1 << d);
    endfunction

    function automatic int ngrp_of(input int d);
        return 16 / lanes_of(d);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    // Entered just after a rising edge with DUT d idle; returns just after the edge raising out_valid.
    task automatic run_block(input int d, input logic [127:0] st, input logic inv,
                             output logic [127:0] res, output int lat);
        in_state_a[d] = st;
        in_inv_a[d]   = inv;
        in_valid_a[d] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[d] = 1'b0;
        lat = 0;
        while (out_valid_a[d] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_state_a[d];
    endtask

    task automatic release_out(input int d);
        out_ready_a[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[d] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_a[d] = 1'b0; in_state_a[d] = '0; in_inv_a[d] = 1'b0; out_ready_a[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready_a[2] !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_a[2]); end
        checks++; if (out_valid_a[2] !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a[2]); end
        checks++; if (busy_a[2] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a[2]); end
        reset = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (in_ready_a[d] !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready[%0d]: got %b want 1", d, in_ready_a[d]); end
        end
    endtask

    task automatic test_forward_vector();
        logic [127:0] res;
        int lat;
        @(posedge clk); #1;
        run_block(2, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, res, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL fwd_vec_latency: got %0d want 4", lat); end
        checks++; if (res !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin errors++; $display("FAIL fwd_vec_state: got %h want 76abd7fe2b670130c56f6bf27b777c63", res); end
        checks++; if (res !== ref_sub(128'h0f0e0d0c0b0a09080706050403020100, 1'b0)) begin errors++; $display("FAIL fwd_vec_model: got %h want %h", res, ref_sub(128'h0f0e0d0c0b0a09080706050403020100, 1'b0)); end
        release_out(2);
        checks++; if (out_valid_a[2] !== 1'b0) begin errors++; $display("FAIL fwd_vec_valid_drop: got %b want 0", out_valid_a[2]); end
        checks++; if (in_ready_a[2] !== 1'b1 || busy_a[2] !== 1'b0) begin errors++; $display("FAIL fwd_vec_idle: got rdy=%b busy=%b want rdy=1 busy=0", in_ready_a[2], busy_a[2]); end
    endtask

    task automatic test_inverse_roundtrip();
        logic [127:0] res;
        logic [127:0] orig;
        int lat;
        orig = 128'h0f0e0d0c0b0a09080706050403020100;
        @(posedge clk); #1;
        run_block(2, 128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1, res, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL inv_latency: got %0d want 4", lat); end
        checks++; if (res !== orig) begin errors++; $display("FAIL inv_roundtrip: got %h want %h", res, orig); end
        release_out(2);
    endtask

    task automatic test_random_blocks();
        logic [127:0] st, res, exp;
        logic inv;
        int lat;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            st  = rand128();
            inv = 1'($urandom_range(0, 1));
            exp = ref_sub(st, inv);
            run_block(2, st, inv, res, lat);
            checks++; if (res !== exp) begin errors++; $display("FAIL random_state[%0d] inv=%b: got %h want %h", n, inv, res, exp); end
            checks++; if (lat != 4) begin errors++; $display("FAIL random_latency[%0d]: got %0d want 4", n, lat); end
            release_out(2);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] st, res, exp;
        int lat;
        int stray;
        @(posedge clk); #1;
        st  = rand128();
        exp = ref_sub(st, 1'b0);
        run_block(2, st, 1'b0, res, lat);
        checks++; if (res !== exp) begin errors++; $display("FAIL bp_state: got %h want %h", res, exp); end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_state_a[2] = ~st; in_inv_a[2] = 1'b1; in_valid_a[2] = 1'b1;
            end
            @(posedge clk); #1;
            in_valid_a[2] = 1'b0;
            checks++; if (out_valid_a[2] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid_a[2]); end
            checks++; if (out_state_a[2] !== exp) begin errors++; $display("FAIL bp_hold_state[%0d]: got %h want %h", c, out_state_a[2], exp); end
            checks++; if (in_ready_a[2] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready_a[2]); end
        end
        release_out(2);
        checks++; if (out_valid_a[2] !== 1'b0 || busy_a[2] !== 1'b0) begin errors++; $display("FAIL bp_single_transfer: got valid=%b busy=%b want 0/0", out_valid_a[2], busy_a[2]); end
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid_a[2] !== 1'b0 || busy_a[2] !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL bp_pulse_ignored: got %0d busy/valid cycles want 0", stray); end
    endtask

    task automatic test_async_reset();
        logic [127:0] res;
        int lat;
        @(posedge clk); #1;
        in_state_a[2] = rand128(); in_inv_a[2] = 1'b0; in_valid_a[2] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy_a[2] !== 1'b1) begin errors++; $display("FAIL arst_busy_before: got %b want 1", busy_a[2]); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid_a[2] !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid_a[2]); end
        checks++; if (busy_a[2] !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy_a[2]); end
        checks++; if (in_ready_a[2] !== 1'b0) begin errors++; $display("FAIL arst_in_ready: got %b want 0", in_ready_a[2]); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (out_valid_a[2] !== 1'b0 || in_ready_a[2] !== 1'b1) begin errors++; $display("FAIL arst_release: got valid=%b rdy=%b want 0/1", out_valid_a[2], in_ready_a[2]); end
        run_block(2, 128'h0, 1'b0, res, lat);
        checks++; if (res !== {16{8'h63}}) begin errors++; $display("FAIL arst_zero_block: got %h want all 63", res); end
        checks++; if (lat != 4) begin errors++; $display("FAIL arst_latency: got %0d want 4", lat); end
        release_out(2);
    endtask

    task automatic test_lanes_sweep();
        logic [127:0] res, exp, got;
        logic took;
        int lat, cyc, n_acc, n_out;
        int acc_cyc [$];
        logic [127:0] expq [$];
        for (int d = 0; d < 5; d++) begin
            @(posedge clk); #1;
            run_block(d, {16{8'h53}}, 1'b0, res, lat);
            checks++; if (res !== {16{8'hed}}) begin errors++; $display("FAIL sweep_state L=%0d: got %h want all ed", lanes_of(d), res); end
            checks++; if (lat != ngrp_of(d)) begin errors++; $display("FAIL sweep_latency L=%0d: got %0d want %0d", lanes_of(d), lat, ngrp_of(d)); end
            release_out(d);

            // Back-to-back: input always offered, output always drained.
            acc_cyc.delete(); expq.delete();
            cyc = 0; n_acc = 0; n_out = 0;
            out_ready_a[d] = 1'b1;
            in_state_a[d]  = rand128();
            in_inv_a[d]    = 1'($urandom_range(0, 1));
            in_valid_a[d]  = 1'b1;
            while ((n_acc < 3 || n_out < 3) && cyc < 300) begin
                took = in_valid_a[d] & in_ready_a[d];
                if (out_valid_a[d] === 1'b1) begin
                    got = out_state_a[d];
                    exp = (expq.size() > 0) ? expq.pop_front() : ~got;
                    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_state L=%0d #%0d: got %h want %h", lanes_of(d), n_out, got, exp); end
                    n_out++;
                end
                if (took) begin
                    expq.push_back(ref_sub(in_state_a[d], in_inv_a[d]));
                    acc_cyc.push_back(cyc);
                    n_acc++;
                end
                @(posedge clk); #1;
                cyc++;
                if (took) begin
                    in_state_a[d] = rand128();
                    in_inv_a[d]   = 1'($urandom_range(0, 1));
                    if (n_acc == 3) in_valid_a[d] = 1'b0;
                end
            end
            out_ready_a[d] = 1'b0;
            in_valid_a[d]  = 1'b0;
            checks++; if (n_acc != 3 || n_out != 3) begin errors++; $display("FAIL b2b_count L=%0d: got acc=%0d out=%0d want 3/3", lanes_of(d), n_acc, n_out); end
            // Accept edges sit NGRP+2 apart: NGRP+1 BUSY/DONE cycles between handshakes.
            if (acc_cyc.size() == 3) begin
                for (int k = 1; k < 3; k++) begin
                    checks++;
                    if (acc_cyc[k] - acc_cyc[k-1] != ngrp_of(d) + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing L=%0d: got %0d want %0d", lanes_of(d), acc_cyc[k] - acc_cyc[k-1], ngrp_of(d) + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_inv_disabled();
        logic [127:0] st, res, exp;
        int lat;
        @(posedge clk); #1;
        run_block(5, {16{8'h63}}, 1'b1, res, lat);
        checks++; if (res !== {16{8'hfb}}) begin errors++; $display("FAIL fwdonly_state: got %h want all fb", res); end
        checks++; if (lat != 4) begin errors++; $display("FAIL fwdonly_latency: got %0d want 4", lat); end
        release_out(5);
        @(posedge clk); #1;
        st  = rand128();
        exp = ref_sub(st, 1'b0);
        run_block(5, st, 1'b1, res, lat);
        checks++; if (res !== exp) begin errors++; $display("FAIL fwdonly_random: got %h want %h", res, exp); end
        release_out(5);
    endtask

    initial begin
        build_tables();
        test_reset();
        test_forward_vector();
        test_inverse_roundtrip();
        test_random_blocks();
        test_backpressure();
        test_async_reset();
        test_lanes_sweep();
        test_inv_disabled();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
